mini_soc: RTL and testbench



---
 rtl/mini_soc_pkg.sv | 23 ++
 rtl/mini_soc_if.sv | 21 ++
 rtl/mini_soc_ram.sv | 28 ++
 rtl/rv32_core.sv | 129 ++++++++++++
 rtl/rv32_id.sv | 45 ++++
 rtl/rv32_if.sv | 15 +
 rtl/rv32_regfile.sv | 22 ++
 rtl/mini_soc.sv | 65 ++++++
 tb/tb_mini_soc.sv | 156 +++++++++++++++
 9 files changed

// File: rtl/mini_soc_pkg.sv
// Shared constants for the mini SoC: address map, region decode enum and RV32I opcodes.
package mini_soc_pkg;

    localparam logic [31:0] GPIO_ADDR = 32'h4000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_GPIO,
        REG_NONE
    } region_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/mini_soc_if.sv
// Core-to-memory bus: word-aligned instruction fetch port plus byte-masked data port.
interface mini_soc_if;
    logic [31:0] iram_addr;
    logic [31:0] iram_rdata;
    logic        dram_req;
    logic        dram_we;
    logic [31:0] dram_addr;
    logic [31:0] dram_wdata;
    logic [3:0]  dram_wmask;
    logic [31:0] dram_rdata;

    modport master (
        output iram_addr, dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        input  iram_rdata, dram_rdata
    );

    modport slave (
        input  iram_addr, dram_req, dram_we, dram_addr, dram_wdata, dram_wmask,
        output iram_rdata, dram_rdata
    );
endinterface

// File: rtl/mini_soc_ram.sv
// Unified RAM: read-only port A and read/byte-write port B, both with one cycle read latency.
module mini_soc_ram #(
    parameter int AW = 22
) (
    input  logic          clk,
    input  logic [AW-3:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic [AW-3:0] b_addr,
    input  logic          b_we,
    input  logic [3:0]    b_wmask,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [0:2**(AW-2)-1];

    // Non-blocking reads sample the array before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
        if (b_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (b_wmask[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/rv32_core.sv
// Multi-cycle RV32I core: FETCH waits out RAM latency, EXEC retires, LOAD collects read data.
module rv32_core
    import mini_soc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_b,
    mini_soc_if.master bus
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} state_t;

    state_t      state, state_next;
    logic        pc_we, rd_we, take;
    logic [31:0] pc, pc_next, rd_wdata;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1_val, rs2_val, imm;
    logic [31:0] alu_b, alu_y, addr, ld_shift, ld_val, st_data;
    logic [3:0]  st_mask;

    rv32_if u_if (.clk(clk), .rst_b(rst_b), .pc_we(pc_we), .pc_next(pc_next), .pc(pc));

    rv32_id u_id (
        .clk(clk), .instr(bus.iram_rdata), .rd_we(rd_we), .rd_wdata(rd_wdata),
        .opcode(opcode), .rd(rd), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm)
    );

    // pc is held from FETCH through LOAD, so iram_rdata keeps presenting the current instruction.
    assign bus.iram_addr = pc;
    assign addr     = rs1_val + imm;
    assign alu_b    = (opcode == OP_REG) ? rs2_val : imm;
    assign ld_shift = bus.dram_rdata >> {addr[1:0], 3'b000};
    assign st_data  = rs2_val << {addr[1:0], 3'b000};

    always_comb begin
        case (funct3)
            3'd0:    alu_y = (opcode == OP_REG && funct7b5) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1:    alu_y = rs1_val << alu_b[4:0];
            3'd2:    alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'd3:    alu_y = {31'b0, rs1_val < alu_b};
            3'd4:    alu_y = rs1_val ^ alu_b;
            3'd5:    alu_y = funct7b5 ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'd6:    alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    take = (rs1_val == rs2_val);
            3'd1:    take = (rs1_val != rs2_val);
            3'd4:    take = ($signed(rs1_val) < $signed(rs2_val));
            3'd5:    take = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6:    take = (rs1_val < rs2_val);
            3'd7:    take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3)
            3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'd4:    ld_val = {24'b0, ld_shift[7:0]};
            3'd5:    ld_val = {16'b0, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
        case (funct3[1:0])
            2'd0:    st_mask = 4'b0001 << addr[1:0];
            2'd1:    st_mask = 4'b0011 << {addr[1], 1'b0};
            default: st_mask = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        pc_we          = 1'b0;
        pc_next        = pc + 32'd4;
        rd_we          = 1'b0;
        rd_wdata       = alu_y;
        bus.dram_req   = 1'b0;
        bus.dram_we    = 1'b0;
        bus.dram_addr  = addr;
        bus.dram_wdata = st_data;
        bus.dram_wmask = '0;
        case (state)
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                pc_we      = 1'b1;
                case (opcode)
                    OP_LOAD: begin
                        bus.dram_req = 1'b1;
                        pc_we        = 1'b0;
                        state_next   = S_LOAD;
                    end
                    OP_STORE: begin
                        bus.dram_req   = 1'b1;
                        bus.dram_we    = 1'b1;
                        bus.dram_wmask = st_mask;
                    end
                    OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm; end
                    OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc + imm; end
                    OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = pc + imm; end
                    OP_JALR:  begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = addr & ~32'd1; end
                    OP_BRANCH: if (take) pc_next = pc + imm;
                    OP_IMM, OP_REG: rd_we = 1'b1;
                    default: ;
                endcase
            end
            S_LOAD: begin
                rd_we      = 1'b1;
                rd_wdata   = ld_val;
                pc_we      = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/rv32_id.sv
// Instruction decode: field extraction, immediate formation and register file access.
module rv32_id
    import mini_soc_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] instr,
    input  logic        rd_we,
    input  logic [31:0] rd_wdata,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic [31:0] imm
);

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];

    rv32_regfile u_regfile (
        .clk     (clk),
        .rs1     (instr[19:15]),
        .rs2     (instr[24:20]),
        .rd      (rd),
        .we      (rd_we),
        .wdata   (rd_wdata),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val)
    );

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (opcode)
            OP_STORE:        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:       imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm = {instr[31:12], 12'b0};
            OP_JAL:          imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:         ;
        endcase
    end

endmodule

// File: rtl/rv32_if.sv
// Program counter register; resets to address zero.
module rv32_if (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)     pc <= '0;
        else if (pc_we) pc <= pc_next;
    end

endmodule

// File: rtl/rv32_regfile.sv
// 32 x 32-bit integer register file, x0 hardwired to zero, asynchronous reads.
module rv32_regfile (
    input  logic        clk,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val
);

    logic [31:0] register [0:31];

    always_ff @(posedge clk) begin
        if (we && rd != '0) register[rd] <= wdata;
    end

    assign rs1_val = (rs1 == '0) ? '0 : register[rs1];
    assign rs2_val = (rs2 == '0) ? '0 : register[rs2];

endmodule

// File: rtl/mini_soc.sv
// SoC top: RV32 core, unified instruction/data RAM, address decode, read mux and 8-bit GPIO.
module mini_soc
    import mini_soc_pkg::*;
#(
    parameter int RAM_AW = 22
) (
    input  logic       clk,
    input  logic       rst_b,
    output logic [7:0] GPIO
);

    mini_soc_if bus ();

    region_t     region, region_q;
    logic        ram_we, gpio_we;
    logic [31:0] ram_rdata;
    logic [7:0]  gpio_q;
    logic        unused;

    rv32_core u_core (.clk(clk), .rst_b(rst_b), .bus(bus.master));

    // GPIO owns the whole word at GPIO_ADDR; only byte lane 0 is backed by storage.
    always_comb begin
        region = REG_NONE;
        if (bus.dram_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]) region = REG_RAM;
        else if (bus.dram_addr[31:2] == GPIO_ADDR[31:2])     region = REG_GPIO;
    end

    assign ram_we  = bus.dram_req & bus.dram_we & (region == REG_RAM);
    assign gpio_we = bus.dram_req & bus.dram_we & (region == REG_GPIO) & bus.dram_wmask[0];

    mini_soc_ram #(.AW(RAM_AW)) memory (
        .clk     (clk),
        .a_addr  (bus.iram_addr[RAM_AW-1:2]),
        .a_rdata (bus.iram_rdata),
        .b_addr  (bus.dram_addr[RAM_AW-1:2]),
        .b_we    (ram_we),
        .b_wmask (bus.dram_wmask),
        .b_wdata (bus.dram_wdata),
        .b_rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gpio_q   <= '0;
            region_q <= REG_NONE;
        end else begin
            if (gpio_we) gpio_q <= bus.dram_wdata[7:0];
            region_q <= bus.dram_req ? region : REG_NONE;
        end
    end

    always_comb begin
        bus.dram_rdata = '0;
        case (region_q)
            REG_RAM:  bus.dram_rdata = ram_rdata;
            REG_GPIO: bus.dram_rdata = {24'b0, gpio_q};
            default:  ;
        endcase
    end

    assign GPIO   = gpio_q;
    assign unused = ^{bus.iram_addr[31:RAM_AW], bus.iram_addr[1:0], bus.dram_addr[1:0]};

endmodule

// File: tb/tb_mini_soc.sv
// Directed bench for mini_soc: runs a small preloaded program and checks RAM, GPIO and registers.
module tb_mini_soc;

    logic        clk   = 1'b0;
    logic        rst_b = 1'b0;
    logic [7:0]  gpio;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [0:20];

    mini_soc #(.RAM_AW(22)) dut (.clk(clk), .rst_b(rst_b), .GPIO(gpio));

    mini_soc_if mon ();
    assign mon.iram_addr  = dut.bus.iram_addr;
    assign mon.iram_rdata = dut.bus.iram_rdata;
    assign mon.dram_req   = dut.bus.dram_req;
    assign mon.dram_we    = dut.bus.dram_we;
    assign mon.dram_addr  = dut.bus.dram_addr;
    assign mon.dram_wdata = dut.bus.dram_wdata;
    assign mon.dram_wmask = dut.bus.dram_wmask;
    assign mon.dram_rdata = dut.bus.dram_rdata;

    // Stand-alone RAM instance for driving exact same-cycle read/write collisions.
    logic [3:0]  c_a_addr = '0, c_b_addr = '0, c_mask = '0;
    logic        c_we = 1'b0;
    logic [31:0] c_wdata = '0, c_a_rdata, c_b_rdata;

    mini_soc_ram #(.AW(6)) u_ram_c (
        .clk(clk), .a_addr(c_a_addr), .a_rdata(c_a_rdata), .b_addr(c_b_addr),
        .b_we(c_we), .b_wmask(c_mask), .b_wdata(c_wdata), .b_rdata(c_b_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_pc(input logic [31:0] target);
        int unsigned n;
        n = 0;
        while (dut.u_core.u_if.pc !== target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (dut.u_core.u_if.pc !== target) check_eq("pc_timeout", dut.u_core.u_if.pc, target);
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    initial begin
        prog[0]  = enc_u(20'h12345, 1);
        prog[1]  = enc_i(12'h678, 1, 3'd0, 1, 7'b0010011);
        prog[2]  = enc_u(20'h00004, 2);
        prog[3]  = enc_s(12'hFF0, 1, 2, 3'd2);
        prog[4]  = enc_i(12'hFF0, 2, 3'd2, 3, 7'b0000011);
        prog[5]  = enc_u(20'h11223, 4);
        prog[6]  = enc_i(12'h344, 4, 3'd0, 4, 7'b0010011);
        prog[7]  = enc_s(12'hFF0, 4, 2, 3'd2);
        prog[8]  = enc_i(12'h0AB, 0, 3'd0, 5, 7'b0010011);
        prog[9]  = enc_s(12'hFF1, 5, 2, 3'd0);
        prog[10] = enc_u(20'h40000, 6);
        prog[11] = enc_i(12'h0A5, 0, 3'd0, 7, 7'b0010011);
        prog[12] = enc_s(12'h000, 7, 6, 3'd2);
        prog[13] = enc_i(12'h000, 6, 3'd2, 8, 7'b0000011);
        prog[14] = enc_i(12'h05A, 0, 3'd0, 9, 7'b0010011);
        prog[15] = enc_s(12'h001, 9, 6, 3'd0);
        prog[16] = enc_u(20'h20000, 10);
        prog[17] = enc_s(12'h000, 1, 10, 3'd2);
        prog[18] = enc_i(12'hFFF, 0, 3'd0, 11, 7'b0010011);
        prog[19] = enc_i(12'h000, 10, 3'd2, 11, 7'b0000011);
        prog[20] = 32'h0000_006F;
        for (int i = 0; i < 21; i++) dut.memory.mem[i] = prog[i];
        u_ram_c.mem[5] = 32'h0102_0304;

        repeat (5) @(negedge clk);
        check_eq("rst_gpio", {24'b0, gpio}, 32'h0);
        check_eq("rst_pc", dut.u_core.u_if.pc, 32'h0);
        rst_b = 1'b1;
        #1 check_eq("fetch_addr", mon.iram_addr, 32'h0);
        @(negedge clk);
        check_eq("fetch_data", mon.iram_rdata, prog[0]);

        wait_pc(32'd16);
        check_eq("sw_word", dut.memory.mem[12'hFFC], 32'h1234_5678);
        wait_pc(32'd20);
        check_eq("lw_x3", dut.u_core.u_id.u_regfile.register[3], 32'h1234_5678);
        wait_pc(32'd40);
        check_eq("sb_word", dut.memory.mem[12'hFFC], 32'h1122_AB44);
        wait_pc(32'd52);
        check_eq("gpio_store", {24'b0, gpio}, 32'h0000_00A5);
        wait_pc(32'd56);
        check_eq("gpio_load", dut.u_core.u_id.u_regfile.register[8], 32'h0000_00A5);
        wait_pc(32'd64);
        check_eq("gpio_mask", {24'b0, gpio}, 32'h0000_00A5);
        wait_pc(32'd80);
        check_eq("unmap_load", dut.u_core.u_id.u_regfile.register[11], 32'h0);
        check_eq("unmap_mem0", dut.memory.mem[0], prog[0]);
        check_eq("unmap_memffc", dut.memory.mem[12'hFFC], 32'h1122_AB44);
        check_eq("x1_value", dut.u_core.u_id.u_regfile.register[1], 32'h1234_5678);

        // Reset in the middle of the idle loop, then let the program run again.
        @(posedge clk);
        #2 rst_b = 1'b0;
        #1;
        check_eq("midrst_gpio", {24'b0, gpio}, 32'h0);
        check_eq("midrst_pc", dut.u_core.u_if.pc, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("midrst_ram", dut.memory.mem[12'hFFC], 32'h1122_AB44);
        rst_b = 1'b1;
        wait_pc(32'd48);
        check_eq("rerun_gpio0", {24'b0, gpio}, 32'h0);
        wait_pc(32'd52);
        check_eq("rerun_gpio", {24'b0, gpio}, 32'h0000_00A5);
        wait_pc(32'd80);
        check_eq("rerun_x11", dut.u_core.u_id.u_regfile.register[11], 32'h0);

        @(negedge clk);
        c_a_addr = 4'd5;
        c_b_addr = 4'd5;
        c_we     = 1'b1;
        c_mask   = 4'b1111;
        c_wdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("coll_a_old", c_a_rdata, 32'h0102_0304);
        check_eq("coll_b_old", c_b_rdata, 32'h0102_0304);
        c_mask  = 4'b0100;
        c_wdata = 32'h0077_0000;
        @(negedge clk);
        check_eq("coll_a_new", c_a_rdata, 32'hDEAD_BEEF);
        c_we = 1'b0;
        @(negedge clk);
        check_eq("coll_lane2", c_a_rdata, 32'hDE77_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
